// File: rtl/data_memory_wbuf.sv
// data_memory_wbuf: word-addressed data memory with a posted-store
// FIFO write buffer (WB) and youngest-entry load forwarding.
//
// Optional feature macro: DMEM_WBUF_EN
//   defined   -> stores post into the WB and drain on load-free cycles
//   undefined -> stores write the RAM directly; Stall and WB_Count are 0
//
// Ports:
//   CLK       clock, all state updates on posedge
//   rst       synchronous active-high reset (WB state only; RAM kept)
//   MemWrite  store this cycle
//   MemRead   load this cycle (RAM port busy, no drain)
//   A         byte address; A[1:0] and bits above the index ignored
//   WD        store data
//   RD        load data, combinational, valid regardless of MemRead
//   Stall     store not accepted this cycle (WB full)
//   WB_Count  occupied WB entries
module data_memory_wbuf #(
    parameter  int DEPTH_WORDS = 256,
    parameter  int WB_DEPTH    = 4,
    localparam int IDX_W       = $clog2(DEPTH_WORDS),
    localparam int CNT_W       = $clog2(WB_DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [31:0]      A,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    output logic             Stall,
    output logic [CNT_W-1:0] WB_Count
);

    if (DEPTH_WORDS < 4 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("DEPTH_WORDS must be a power of 2, >= 4");
    end

    if (WB_DEPTH < 2 || WB_DEPTH > 16 ||
        (WB_DEPTH & (WB_DEPTH - 1)) != 0) begin : g_bad_wb
        $error("WB_DEPTH must be a power of 2 in 2..16");
    end

    logic [IDX_W-1:0] idx;
    logic             unused_a;

    // Upper address bits alias modulo the array size.
    assign idx      = A[IDX_W+1:2];
    assign unused_a = ^{A[31:IDX_W+2], A[1:0]};

    // Unreset storage: contents survive rst.
    logic [31:0] mem [DEPTH_WORDS];

`ifdef DMEM_WBUF_EN

    localparam int               PTR_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(WB_DEPTH);

    logic [IDX_W-1:0]    tag_q [WB_DEPTH];
    logic [31:0]         dat_q [WB_DEPTH];
    logic [WB_DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic             full;
    logic             enq;
    logic             drn;
    logic             fwd_hit;
    logic [31:0]      fwd_dat;
    logic [PTR_W-1:0] pos;

    assign full     = (cnt_q == FULL);
    assign Stall    = MemWrite & full;
    assign enq      = MemWrite & ~full;
    // MemRead owns the RAM port; with MemRead&MemWrite the store
    // still enqueues but nothing drains.
    assign drn      = (cnt_q != '0) & ~MemRead;
    assign WB_Count = cnt_q;

    // Enqueue and drain never hit the same slot: head==tail only
    // when empty (no drain) or full (no enqueue).
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        vld_d  = vld_q;
        if (enq) begin
            tail_d        = tail_q + PTR_W'(1);
            vld_d[tail_q] = 1'b1;
        end
        if (drn) begin
            head_d        = head_q + PTR_W'(1);
            vld_d[head_q] = 1'b0;
        end
        unique case ({enq, drn})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            vld_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
        end
    end

    // Payload needs no reset; validity is tracked by vld_q.
    always_ff @(posedge CLK) begin
        if (enq && !rst) begin
            tag_q[tail_q] <= idx;
            dat_q[tail_q] <= WD;
        end
    end

    always_ff @(posedge CLK) begin
        if (drn && !rst) begin
            mem[tag_q[head_q]] <= dat_q[head_q];
        end
    end

    // Walk entries oldest to youngest starting at head, so the last
    // match is the youngest even when the pointers have wrapped.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        pos     = head_q;
        for (int k = 0; k < WB_DEPTH; k++) begin
            pos = head_q + PTR_W'(k);
            if (vld_q[pos] && (tag_q[pos] == idx)) begin
                fwd_hit = 1'b1;
                fwd_dat = dat_q[pos];
            end
        end
    end

    assign RD = fwd_hit ? fwd_dat : mem[idx];

`else

    logic unused_nowb;

    assign unused_nowb = rst ^ MemRead;
    assign Stall       = 1'b0;
    assign WB_Count    = '0;
    assign RD          = mem[idx];

    always_ff @(posedge CLK) begin
        if (MemWrite) begin
            mem[idx] <= WD;
        end
    end

`endif

endmodule

// File: tb/tb_data_memory_wbuf.sv
// tb_data_memory_wbuf: directed checks of data_memory_wbuf with
// DEPTH_WORDS=256, WB_DEPTH=4, for both DMEM_WBUF_EN builds.
module tb_data_memory_wbuf;

`ifdef DMEM_WBUF_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mw;
    logic        mr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic [2:0]  cnt;

    int checks = 0;
    int errors = 0;

    data_memory_wbuf #(
        .DEPTH_WORDS(256),
        .WB_DEPTH   (4)
    ) dut (
        .CLK     (clk),
        .rst     (rst),
        .MemWrite(mw),
        .MemRead (mr),
        .A       (a),
        .WD      (wd),
        .RD      (rd),
        .Stall   (stall),
        .WB_Count(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic [31:0] ad, input logic [31:0] d);
        mw = w;
        mr = r;
        a  = ad;
        wd = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mw  = 1'b0;
        mr  = 1'b0;
        a   = '0;
        wd  = '0;
        tick();
        tick();
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 1'b0;

        // 1: store, forward, drain
        drive(1, 0, 32'h10, 32'hDEADBEEF);
        chk("t1_stall", 32'(stall), 0);
        tick();
        drive(0, 1, 32'h10, 0);
        chk("t1_fwd", rd, 32'hDEADBEEF);
        chk("t1_cnt", 32'(cnt), WB ? 1 : 0);
        tick();
        drive(0, 0, 32'h10, 0);
        tick();
        chk("t1_drained", 32'(cnt), 0);
        chk("t1_ram", rd, 32'hDEADBEEF);

        // 2: two stores to one word, last writer wins
        drive(1, 0, 32'h20, 1);
        tick();
        drive(1, 0, 32'h20, 2);
        tick();
        drive(0, 1, 32'h20, 0);
        chk("t2_fwd", rd, 2);
        tick();
        drive(0, 0, 32'h20, 0);
        tick();
        tick();
        chk("t2_cnt", 32'(cnt), 0);
        chk("t2_ram", rd, 2);

        // 3: fill under MemRead, youngest forward, stall, wrap
        drive(1, 1, 32'h40, 11);
        tick();
        drive(1, 1, 32'h44, 22);
        tick();
        drive(1, 1, 32'h40, 33);
        tick();
        drive(1, 1, 32'h48, 44);
        tick();
        drive(0, 1, 32'h40, 0);
        chk("t3_full", 32'(cnt), WB ? 4 : 0);
        chk("t3_fwd40", rd, 33);
        tick();
        drive(0, 1, 32'h44, 0);
        chk("t3_fwd44", rd, 22);
        tick();
        drive(0, 1, 32'h48, 0);
        chk("t3_fwd48", rd, 44);
        chk("t3_hold", 32'(cnt), WB ? 4 : 0);
        tick();
        drive(1, 0, 32'h40, 55);
        chk("t3_stall", 32'(stall), WB ? 1 : 0);
        chk("t3_cnt_st", 32'(cnt), WB ? 4 : 0);
        tick();
        drive(1, 1, 32'h40, 55);
        chk("t3_unstall", 32'(stall), 0);
        chk("t3_cnt3", 32'(cnt), WB ? 3 : 0);
        tick();
        drive(0, 1, 32'h40, 0);
        chk("t3_cnt4", 32'(cnt), WB ? 4 : 0);
        chk("t3_wrapfwd", rd, 55);
        tick();
        drive(0, 0, 32'h44, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_empty", 32'(cnt), 0);
        drive(0, 1, 32'h40, 0);
        chk("t3_ram40", rd, 55);
        drive(0, 1, 32'h44, 0);
        chk("t3_ram44", rd, 22);
        drive(0, 1, 32'h48, 0);
        chk("t3_ram48", rd, 44);
        tick();

        // 4: reset discards queued stores, RAM kept
        drive(1, 0, 32'h80, 32'h1111);
        tick();
        drive(1, 0, 32'h84, 32'h2222);
        tick();
        drive(1, 0, 32'h88, 32'h3333);
        tick();
        drive(0, 0, 32'h80, 0);
        tick();
        tick();
        chk("t4_pre", 32'(cnt), 0);
        drive(1, 1, 32'h80, 32'hAAAA);
        tick();
        drive(0, 1, 32'h80, 0);
        chk("t4_fwd80", rd, 32'hAAAA);
        tick();
        drive(1, 1, 32'h84, 32'hBBBB);
        tick();
        drive(0, 1, 32'h84, 0);
        chk("t4_fwd84", rd, 32'hBBBB);
        tick();
        drive(1, 1, 32'h88, 32'hCCCC);
        tick();
        rst = 1'b1;
        drive(1, 0, 32'h8C, 32'hDDDD);
        chk("t4_queued", 32'(cnt), WB ? 3 : 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 32'h80, 0);
        chk("t4_rst_cnt", 32'(cnt), 0);
        chk("t4_rst_stall", 32'(stall), 0);
        chk("t4_ram80", rd, WB ? 32'h1111 : 32'hAAAA);
        drive(0, 0, 32'h84, 0);
        chk("t4_ram84", rd, WB ? 32'h2222 : 32'hBBBB);
        drive(0, 0, 32'h88, 0);
        chk("t4_ram88", rd, WB ? 32'h3333 : 32'hCCCC);
        tick();

        // 5: aliasing modulo 1 KiB
        drive(1, 0, 32'h400, 32'hA5A5A5A5);
        tick();
        drive(0, 1, 32'h000, 0);
        chk("t5_fwd", rd, 32'hA5A5A5A5);
        chk("t5_cnt", 32'(cnt), WB ? 1 : 0);
        tick();
        drive(0, 0, 32'h000, 0);
        tick();
        drive(0, 1, 32'h000, 0);
        chk("t5_ram", rd, 32'hA5A5A5A5);
        chk("t5_empty", 32'(cnt), 0);
        tick();

        // 6: store then load next cycle
        drive(1, 0, 32'h8, 32'h1234);
        chk("t6_stall", 32'(stall), 0);
        tick();
        drive(0, 1, 32'h8, 0);
        chk("t6_rd", rd, 32'h1234);
        chk("t6_cnt", 32'(cnt), WB ? 1 : 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
